// File: rtl/posicionamento_ctrl.sv
// rtl/posicionamento_ctrl.sv - fleet placement sequencer driving the placement validator
// Optional macro AUTO_POS_EN: coordinates come from an internal 16-bit LFSR instead of the handshake.
`timescale 1ns/1ps
module posicionamento_ctrl #(
    parameter int MAX_TENT    = 8,
    parameter int TIMEOUT_CYC = 64
`ifdef AUTO_POS_EN
    ,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       coord_req,
    input  logic       coord_valid,
    input  logic [3:0] x_in,
    input  logic [3:0] y_in,
    input  logic       dir_in,
    input  logic [2:0] ori_in,
    output logic       val_enable,
    output logic [2:0] val_tipo,
    output logic       val_direcao,
    output logic [2:0] val_orientacao,
    output logic [3:0] val_x1,
    output logic [3:0] val_y1,
    output logic       val_jogador,
    input  logic       val_ready,
    input  logic       val_conflito,
    output logic [3:0] navio_idx,
    output logic [3:0] tentativas,
    output logic       busy,
    output logic       done,
    output logic       falha,
    output logic       timeout_flag
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_LAUNCH, S_NEXT, S_DONE, S_FAIL} state_t;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t        state, state_nx;
    logic [TW-1:0] timer;
    logic [3:0]    idx, tent, tent_inc;
    logic          jogador;
    logic [3:0]    cap_x, cap_y, src_x, src_y;
    logic          cap_dir, src_dir;
    logic [2:0]    cap_ori, src_ori;
    logic          got_coord, timed_out, conflict, last_ship;

`ifdef AUTO_POS_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign got_coord = 1'b1;
    assign coord_req = 1'b0;
    assign src_x     = {1'b0, lfsr[2:0]};
    assign src_y     = {1'b0, lfsr[5:3]};
    assign src_dir   = lfsr[6];
    assign src_ori   = {1'b0, lfsr[8:7]};
`else
    assign got_coord = coord_valid;
    assign coord_req = (state == S_REQ);
    assign src_x     = x_in;
    assign src_y     = y_in;
    assign src_dir   = dir_in;
    assign src_ori   = ori_in;
`endif

    // A missing val_ready at the end of the window is handled exactly like a conflict.
    assign timed_out = (state == S_LAUNCH) && !val_ready && (timer == TW'(TIMEOUT_CYC - 1));
    assign conflict  = (state == S_LAUNCH) && ((val_ready && val_conflito) || timed_out);
    assign tent_inc  = tent + 4'd1;
    assign last_ship = (idx == 4'd10);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_FAIL: if (start) state_nx = S_REQ;
            S_REQ:    if (got_coord) state_nx = S_LAUNCH;
            S_LAUNCH: begin
                if (val_ready && !val_conflito) state_nx = S_NEXT;
                else if (conflict)              state_nx = (tent_inc == 4'(MAX_TENT)) ? S_FAIL : S_REQ;
            end
            S_NEXT:   state_nx = (last_ship && jogador) ? S_DONE : S_REQ;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer        <= '0;
            idx          <= '0;
            tent         <= '0;
            jogador      <= 1'b0;
            timeout_flag <= 1'b0;
            cap_x        <= '0;
            cap_y        <= '0;
            cap_dir      <= 1'b0;
            cap_ori      <= '0;
        end else begin
            timer <= (state == S_LAUNCH) ? timer + TW'(1) : '0;
            case (state)
                S_IDLE, S_DONE, S_FAIL: if (start) begin
                    jogador      <= 1'b0;
                    idx          <= '0;
                    tent         <= '0;
                    timeout_flag <= 1'b0;
                end
                S_REQ: if (got_coord) begin
                    cap_x   <= src_x;
                    cap_y   <= src_y;
                    cap_dir <= src_dir;
                    cap_ori <= src_ori;
                end
                S_LAUNCH: begin
                    if (conflict)  tent         <= tent_inc;
                    if (timed_out) timeout_flag <= 1'b1;
                end
                S_NEXT: begin
                    tent <= '0;
                    if (!last_ship) begin
                        idx <= idx + 4'd1;
                    end else if (!jogador) begin
                        jogador <= 1'b1;
                        idx     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        val_tipo = 3'b000;
        if (idx == 4'd10)     val_tipo = 3'b100;
        else if (idx == 4'd9) val_tipo = 3'b011;
        else if (idx >= 4'd7) val_tipo = 3'b010;
        else if (idx >= 4'd5) val_tipo = 3'b001;
    end

    assign val_enable     = (state == S_LAUNCH);
    assign val_direcao    = (val_tipo == 3'b000) ? 1'b0 : cap_dir;
    assign val_orientacao = (val_tipo == 3'b010) ? cap_ori : 3'b000;
    assign val_x1         = cap_x;
    assign val_y1         = cap_y;
    assign val_jogador    = jogador;
    assign navio_idx      = idx;
    assign tentativas     = tent;
    assign busy           = (state == S_REQ) || (state == S_LAUNCH) || (state == S_NEXT);
    assign done           = (state == S_DONE) || (state == S_FAIL);
    assign falha          = (state == S_FAIL);
endmodule

// File: tb/tb_posicionamento_ctrl.sv
// tb/tb_posicionamento_ctrl.sv - self-checking bench for posicionamento_ctrl
`timescale 1ns/1ps
module tb_posicionamento_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, start, coord_req, coord_valid, dir_in;
    logic [3:0] x_in, y_in;
    logic [2:0] ori_in;
    logic       val_enable, val_direcao, val_jogador, val_ready, val_conflito;
    logic [2:0] val_tipo, val_orientacao;
    logic [3:0] val_x1, val_y1, navio_idx, tentativas;
    logic       busy, done, falha, timeout_flag;

    posicionamento_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .coord_req(coord_req),
        .coord_valid(coord_valid), .x_in(x_in), .y_in(y_in), .dir_in(dir_in), .ori_in(ori_in),
        .val_enable(val_enable), .val_tipo(val_tipo), .val_direcao(val_direcao),
        .val_orientacao(val_orientacao), .val_x1(val_x1), .val_y1(val_y1),
        .val_jogador(val_jogador), .val_ready(val_ready), .val_conflito(val_conflito),
        .navio_idx(navio_idx), .tentativas(tentativas), .busy(busy), .done(done),
        .falha(falha), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] x, y;
        logic       d;
        logic [2:0] o;
        logic [2:0] tipo, ed, eo;
    } vec_t;
    vec_t tbl[11];

    int n_chk = 0, n_fail = 0;
    int r_en;
    logic [2:0] r_tipo, r_ori;
    logic       r_dir, r_jog;
    logic [3:0] r_x, r_y;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One coord handshake plus one validator phase; delay 0 means the validator never answers.
    task automatic run_attempt(input vec_t v, input int delay, input logic conf);
        bit found = 0;
        r_en = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (coord_req) begin found = 1; break; end
        end
        if (!found) begin
            chk("coord_req_wait", 0, 1);
            return;
        end
        coord_valid = 1'b1;
        x_in = v.x; y_in = v.y; dir_in = v.d; ori_in = v.o;
        val_conflito = conf;
        @(negedge clk);
        coord_valid = 1'b0;
        x_in = 4'hF; y_in = 4'hF; dir_in = ~v.d; ori_in = ~v.o;
        for (int k = 0; k < 200; k++) begin
            val_ready = 1'b0;
            if (!val_enable) break;
            r_en++;
            if (r_en == 1) begin
                r_tipo = val_tipo; r_dir = val_direcao; r_ori = val_orientacao;
                r_x = val_x1; r_y = val_y1; r_jog = val_jogador;
            end
            val_ready = (delay > 0) && (r_en == delay);
            @(negedge clk);
        end
        val_ready = 1'b0;
    endtask

    task automatic place_ok(input int i);
        vec_t v;
        v = tbl[i % 11];
        run_attempt(v, 3, 1'b0);
        chk($sformatf("en_cycles[%0d]", i), r_en, 3);
        chk($sformatf("tipo[%0d]", i), r_tipo, v.tipo);
        chk($sformatf("direcao[%0d]", i), r_dir, v.ed);
        chk($sformatf("orient[%0d]", i), r_ori, v.eo);
        chk($sformatf("x1[%0d]", i), r_x, v.x);
        chk($sformatf("y1[%0d]", i), r_y, v.y);
        chk($sformatf("jogador[%0d]", i), r_jog, (i >= 11) ? 1 : 0);
    endtask

    initial begin
        tbl[0]  = '{4'd1, 4'd2, 1'b1, 3'd5, 3'd0, 3'd0, 3'd0};
        tbl[1]  = '{4'd7, 4'd7, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0};
        tbl[2]  = '{4'd0, 4'd0, 1'b1, 3'd7, 3'd0, 3'd0, 3'd0};
        tbl[3]  = '{4'd3, 4'd4, 1'b1, 3'd1, 3'd0, 3'd0, 3'd0};
        tbl[4]  = '{4'd5, 4'd6, 1'b0, 3'd2, 3'd0, 3'd0, 3'd0};
        tbl[5]  = '{4'd2, 4'd3, 1'b1, 3'd6, 3'd1, 3'd1, 3'd0};
        tbl[6]  = '{4'd4, 4'd1, 1'b0, 3'd4, 3'd1, 3'd0, 3'd0};
        tbl[7]  = '{4'd6, 4'd5, 1'b1, 3'd3, 3'd2, 3'd1, 3'd3};
        tbl[8]  = '{4'd1, 4'd7, 1'b0, 3'd6, 3'd2, 3'd0, 3'd6};
        tbl[9]  = '{4'd7, 4'd0, 1'b1, 3'd2, 3'd3, 3'd1, 3'd0};
        tbl[10] = '{4'd0, 4'd6, 1'b1, 3'd7, 3'd4, 3'd1, 3'd0};

        rst_n = 1'b0; start = 1'b0; coord_valid = 1'b0; x_in = '0; y_in = '0;
        dir_in = 1'b0; ori_in = '0; val_ready = 1'b0; val_conflito = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {coord_req, val_enable, busy, done, falha, timeout_flag, navio_idx, tentativas}, 0);
        rst_n = 1'b1;

        // Full run, both players, no conflicts.
        pulse_start();
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < 22; i++) place_ok(i);
        @(negedge clk);
        chk("full_done", done, 1);
        chk("full_falha", falha, 0);
        chk("full_busy", busy, 0);

        // Two conflicts on ship 5, then fail at ship 9 of player 1.
        pulse_start();
        chk("restart_idx", navio_idx, 0);
        chk("restart_done", done, 0);
        for (int i = 0; i < 5; i++) place_ok(i);
        run_attempt(tbl[5], 3, 1'b1);
        chk("s5_tent1", tentativas, 1);
        run_attempt(tbl[5], 2, 1'b1);
        chk("s5_tent2", tentativas, 2);
        chk("s5_idx_hold", navio_idx, 5);
        run_attempt(tbl[5], 3, 1'b0);
        chk("s5_next_enable_low", val_enable, 0);
        @(negedge clk);
        chk("s6_idx", navio_idx, 6);
        chk("s6_tent", tentativas, 0);
        for (int i = 6; i < 20; i++) place_ok(i);
        for (int a = 0; a < 8; a++) run_attempt(tbl[9], 2, 1'b1);
        chk("fail_done", done, 1);
        chk("fail_falha", falha, 1);
        chk("fail_idx", navio_idx, 9);
        chk("fail_jog", val_jogador, 1);
        chk("fail_tent", tentativas, 8);
        chk("fail_busy", busy, 0);
        chk("fail_no_timeout", timeout_flag, 0);

        // Validator never answers: each attempt holds val_enable for the full window.
        pulse_start();
        for (int a = 0; a < 8; a++) begin
            run_attempt(tbl[0], 0, 1'b0);
            chk($sformatf("timeout_en[%0d]", a), r_en, 64);
        end
        chk("to_flag", timeout_flag, 1);
        chk("to_falha", falha, 1);
        chk("to_tent", tentativas, 8);
        chk("to_idx", navio_idx, 0);

        // Reset in the middle of LAUNCH on ship 3.
        pulse_start();
        chk("to_flag_cleared", timeout_flag, 0);
        for (int i = 0; i < 3; i++) place_ok(i);
        begin
            bit found = 0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (coord_req) begin found = 1; break; end
            end
            chk("s3_req_seen", found, 1);
            coord_valid = 1'b1; x_in = 4'd3; y_in = 4'd4;
            @(negedge clk);
            coord_valid = 1'b0;
            chk("s3_enable", val_enable, 1);
            chk("s3_idx", navio_idx, 3);
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            chk("midrst_enable", val_enable, 0);
            chk("midrst_busy", busy, 0);
            chk("midrst_idx", navio_idx, 0);
            rst_n = 1'b1;
        end
        pulse_start();
        chk("after_rst_busy", busy, 1);
        chk("after_rst_req", coord_req, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
